// File: rtl/adc_capture_sequencer_pkg.sv
// adc_capture_sequencer_pkg
// Shared definitions for the ADC capture sequencer: default widths, the
// FSM state encoding and the full-scale sample codes for the default
// 13-bit two's-complement channel.
package adc_capture_sequencer_pkg;

  localparam int DATA_W_DEF  = 13;
  localparam int DELAY_W_DEF = 8;
  localparam int LEN_W_DEF   = 10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    DELAY   = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Most positive / most negative codes: +4095 and -4096 at 13 bits.
  localparam logic signed [DATA_W_DEF-1:0] SAT_POS = {1'b0, {(DATA_W_DEF-1){1'b1}}};
  localparam logic signed [DATA_W_DEF-1:0] SAT_NEG = {1'b1, {(DATA_W_DEF-1){1'b0}}};

endpackage

// File: rtl/adc_capture_sequencer_capture_window_counter.sv
// capture_window_counter
// Timing helpers for the capture FSM: a loadable down-counter for the
// trigger-to-capture delay and an up-counter for the sample index.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   dly_load/val    load the delay counter with dly_val
//   dly_dec         decrement the delay counter (stops at zero)
//   idx_clr/inc     clear / increment the sample index
//   len             latched capture length (non-zero while capturing)
//   dly_one         delay counter is at its final cycle
//   idx_term        current index is the last sample (len-1)
module capture_window_counter
  import adc_capture_sequencer_pkg::*;
#(
  parameter int DELAY_W = DELAY_W_DEF,
  parameter int LEN_W   = LEN_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dly_load,
  input  logic [DELAY_W-1:0] dly_val,
  input  logic               dly_dec,
  input  logic               idx_clr,
  input  logic               idx_inc,
  input  logic [LEN_W-1:0]   len,
  output logic               dly_one,
  output logic               idx_term
);

  logic [DELAY_W-1:0] dly_cnt;
  logic [LEN_W-1:0]   idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      dly_cnt <= '0;
    end else if (dly_load) begin
      dly_cnt <= dly_val;
    end else if (dly_dec && dly_cnt != '0) begin
      dly_cnt <= dly_cnt - DELAY_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
    end else if (idx_clr) begin
      idx <= '0;
    end else if (idx_inc) begin
      idx <= idx + LEN_W'(1);
    end
  end

  assign dly_one  = (dly_cnt == DELAY_W'(1));
  assign idx_term = (idx == (len - LEN_W'(1)));

endmodule

// File: rtl/adc_capture_sequencer.sv
// adc_capture_sequencer
// Trigger-driven capture controller for one signed ADC channel. Arms on
// command, waits for a fresh trigger rising edge, counts a programmable
// delay, then gates exactly `length` samples onto a valid/last stream.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   arm, abort                single-cycle requests (abort has priority)
//   trig                      synchronous trigger level
//   delay, length             capture setup, latched on arm
//   din                       converted sample stream
//   dout/dout_valid/dout_last captured sample stream
//   armed, busy, done         status
//   sat_count                 full-scale sample count of the last capture
// Build option: define ADC_SAT_COUNT_EN to enable the saturated-sample
// counter; otherwise sat_count is tied to zero.
//
// state   | meaning
// IDLE    | waiting for arm with a non-zero length
// ARMED   | waiting for a trigger rising edge
// DELAY   | counting trigger-to-first-sample delay
// CAPTURE | forwarding din to dout, one sample per clock
// DONE    | one-cycle done pulse, back to IDLE
module adc_capture_sequencer
  import adc_capture_sequencer_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DELAY_W = DELAY_W_DEF,
  parameter int LEN_W   = LEN_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arm,
  input  logic                     abort,
  input  logic                     trig,
  input  logic [DELAY_W-1:0]       delay,
  input  logic [LEN_W-1:0]         length,
  input  logic signed [DATA_W-1:0] din,
  output logic signed [DATA_W-1:0] dout,
  output logic                     dout_valid,
  output logic                     dout_last,
  output logic                     armed,
  output logic                     busy,
  output logic                     done,
  output logic [LEN_W-1:0]         sat_count
);

  state_t             state;
  logic               trig_q;
  logic               rise;
  logic [DELAY_W-1:0] dly_q;
  logic [LEN_W-1:0]   len_q;
  logic               dly_one;
  logic               idx_term;
  logic               arm_ok;

  assign rise   = trig & ~trig_q;
  assign arm_ok = (state == IDLE) && arm && (length != '0) && !abort;

  capture_window_counter #(
    .DELAY_W (DELAY_W),
    .LEN_W   (LEN_W)
  ) u_window (
    .clk      (clk),
    .rst      (rst),
    .dly_load ((state == ARMED) && rise && !abort),
    .dly_val  (dly_q),
    .dly_dec  (state == DELAY),
    .idx_clr  (state != CAPTURE),
    .idx_inc  (state == CAPTURE),
    .len      (len_q),
    .dly_one  (dly_one),
    .idx_term (idx_term)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      trig_q     <= 1'b0;
      dly_q      <= '0;
      len_q      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      armed      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      trig_q <= trig;
      done   <= 1'b0;
      if (abort) begin
        state      <= IDLE;
        dout_valid <= 1'b0;
        dout_last  <= 1'b0;
        armed      <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            if (arm_ok) begin
              dly_q <= delay;
              len_q <= length;
              armed <= 1'b1;
              busy  <= 1'b1;
              state <= ARMED;
            end
          end
          ARMED: begin
            if (rise) begin
              armed <= 1'b0;
              state <= (dly_q != '0) ? DELAY : CAPTURE;
            end
          end
          DELAY: begin
            if (dly_one) state <= CAPTURE;
          end
          CAPTURE: begin
            dout       <= din;
            dout_valid <= 1'b1;
            if (idx_term) begin
              dout_last <= 1'b1;
              busy      <= 1'b0;
              state     <= DONE;
            end
          end
          DONE: begin
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            done       <= 1'b1;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef ADC_SAT_COUNT_EN
  localparam logic signed [DATA_W-1:0] FS_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] FS_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  logic [LEN_W-1:0] sat_q;

  // Counts exactly the samples that reach dout, so an aborting edge
  // (which captures nothing) does not count.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q <= '0;
    end else if (arm_ok) begin
      sat_q <= '0;
    end else if (!abort && state == CAPTURE && (din == FS_POS || din == FS_NEG)
                 && sat_q != '1) begin
      sat_q <= sat_q + LEN_W'(1);
    end
  end

  assign sat_count = sat_q;
`else
  assign sat_count = '0;
`endif

endmodule

// File: tb/tb_adc_capture_sequencer.sv
module tb_adc_capture_sequencer;
  import adc_capture_sequencer_pkg::*;

  localparam int DW = 13;
  localparam int WW = 8;
  localparam int LW = 10;
`ifdef ADC_SAT_COUNT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, arm, abort, trig;
  logic [WW-1:0]        delay;
  logic [LW-1:0]        length;
  logic signed [DW-1:0] din, dout;
  logic                 dout_valid, dout_last, armed, busy, done;
  logic [LW-1:0]        sat_count;

  adc_capture_sequencer dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .trig(trig),
    .delay(delay), .length(length), .din(din), .dout(dout),
    .dout_valid(dout_valid), .dout_last(dout_last), .armed(armed),
    .busy(busy), .done(done), .sat_count(sat_count)
  );

  typedef struct {
    int                   edge_no;
    logic signed [DW-1:0] val;
    logic                 last;
  } exp_t;

  exp_t sq[$];
  int   dq[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  logic signed [DW-1:0] din_at [0:4095];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // din presented before edge n is din_at[n]
  task automatic cyc(input bit a, input bit ab);
    arm   = a;
    abort = ab;
    din   = din_at[edge_cnt + 1];
    @(posedge clk);
    @(negedge clk);
    arm   = 1'b0;
    abort = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a sample or done.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (dout_valid) begin
        checks++;
        if (sq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid actual dout=%0d with no sample expected (edge %0d)", dout, edge_cnt);
        end else begin
          e = sq.pop_front();
          chk("sample_edge", edge_cnt, e.edge_no);
          chk("dout", dout, e.val);
          chk("dout_last", dout_last, e.last);
        end
      end else if (dout_last) begin
        checks++;
        errors++;
        $display("FAIL last_without_valid actual=1 expected=0 (edge %0d)", edge_cnt);
      end
      if (done) begin
        checks++;
        if (dq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done actual=1 expected=0 (edge %0d)", edge_cnt);
        end else begin
          chk("done_edge", edge_cnt, dq.pop_front());
        end
      end
    end
  end

  // Reference: after trigger rise at edge E the samples are din at edges
  // E+1+D .. E+D+L, last on the final one, done visible after edge E+D+L+1.
  task automatic run_capture(input int d, input int l, input int gap,
                             input bit pre_high, input bit noise, input bit use_pat);
    int e;
    int exp_sat;
    int idx;
    logic signed [DW-1:0] pat [8];
    pat = '{13'sd4095, 13'sd0, -13'sd4096, -13'sd4096, 13'sd5, 13'sd4095, 13'sd1, 13'sd2};
    exp_sat = 0;
    trig   = pre_high;
    delay  = WW'(d);
    length = LW'(l);
    cyc(1'b1, 1'b0);
    chk("armed_after_arm", armed, 1);
    chk("busy_after_arm", busy, 1);
    chk("sat_cleared_on_arm", sat_count, 0);
    delay  = WW'($urandom);
    length = LW'($urandom);
    for (int g = 0; g < gap; g++) begin
      cyc(1'b0, 1'b0);
      chk("armed_hold", armed, 1);
    end
    if (pre_high) begin
      trig = 1'b0;
      cyc(1'b0, 1'b0);
      chk("armed_hold_pre_high", armed, 1);
    end
    trig = 1'b1;
    e = edge_cnt + 1;
    if (use_pat)
      for (int k = 0; k < 8; k++) din_at[e + 1 + d + k] = pat[k];
    for (int k = 0; k < l; k++) begin
      idx = e + 1 + d + k;
      sq.push_back('{edge_no: idx, val: din_at[idx], last: (k == l - 1)});
      if (din_at[idx] == SAT_POS || din_at[idx] == SAT_NEG) exp_sat++;
    end
    if (!SAT_EN) exp_sat = 0;
    if (exp_sat > 1023) exp_sat = 1023;
    dq.push_back(e + d + l + 1);
    cyc(1'b0, 1'b0);
    for (int n = 0; n <= d + l; n++) begin
      bit an;
      an = 1'b0;
      if (noise) begin
        trig   = 1'($urandom_range(0, 1));
        an     = ($urandom_range(0, 3) == 0);
        length = LW'($urandom_range(1, 20));
      end
      cyc(an, 1'b0);
    end
    trig = 1'b0;
    chk("busy_after_done", busy, 0);
    chk("armed_after_done", armed, 0);
    chk("sat_count", sat_count, exp_sat);
  endtask

  initial begin
    int e;
    for (int i = 0; i < 4096; i++) begin
      if ($urandom_range(0, 7) == 0)
        din_at[i] = ($urandom_range(0, 1) == 1) ? SAT_POS : SAT_NEG;
      else
        din_at[i] = DW'($urandom);
    end
    rst = 1'b1; arm = 1'b0; abort = 1'b0; trig = 1'b0;
    delay = '0; length = '0; din = '0;
    @(negedge clk);
    repeat (3) cyc(1'b0, 1'b0);
    rst = 1'b0;
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_last", dout_last, 0);
    chk("rst_armed", armed, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sat", sat_count, 0);

    run_capture(0, 4, 2, 1'b0, 1'b0, 1'b0);
    run_capture(3, 2, 1, 1'b0, 1'b0, 1'b0);
    run_capture(2, 3, 3, 1'b1, 1'b0, 1'b0);

    // abort mid-capture: L=10, abort on the edge that would take index 5
    trig = 1'b0; delay = '0; length = LW'(10);
    cyc(1'b1, 1'b0);
    chk("abort_case_armed", armed, 1);
    cyc(1'b0, 1'b0);
    trig = 1'b1;
    e = edge_cnt + 1;
    for (int k = 0; k < 5; k++)
      sq.push_back('{edge_no: e + 1 + k, val: din_at[e + 1 + k], last: 1'b0});
    cyc(1'b0, 1'b0);
    repeat (5) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    trig = 1'b0;
    chk("abort_valid", dout_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    run_capture(1, 3, 0, 1'b0, 1'b0, 1'b0);

    // abort while armed
    delay = '0; length = LW'(4);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    chk("abort_armed_armed", armed, 0);
    chk("abort_armed_busy", busy, 0);

    // length zero is ignored; abort beats arm in IDLE
    length = '0;
    cyc(1'b1, 1'b0);
    chk("len0_armed", armed, 0);
    chk("len0_busy", busy, 0);
    length = LW'(5);
    cyc(1'b1, 1'b1);
    chk("abort_arm_armed", armed, 0);
    run_capture(0, 1, 0, 1'b0, 1'b0, 1'b0);
    run_capture(4, 1, 1, 1'b0, 1'b0, 1'b0);

    // full-scale pattern, then re-arm clears the count
    run_capture(0, 8, 1, 1'b0, 1'b0, 1'b1);
    run_capture(1, 3, 1, 1'b0, 1'b0, 1'b0);

    for (int r = 0; r < 12; r++)
      run_capture($urandom_range(0, 5), $urandom_range(1, 12), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), 1'b1, 1'b0);

    repeat (4) cyc(1'b0, 1'b0);
    chk("samples_outstanding", sq.size(), 0);
    chk("done_outstanding", dq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_capture_sequencer.md
Name: adc_capture_sequencer

Overview:
Trigger-driven capture controller for one 13-bit signed ADC channel. It sits downstream of the offset-binary to two's-complement data register stage.
- Arms on command, waits for a trigger rising edge, then counts a programmable pre-delay.
- Gates exactly LENGTH consecutive converted samples onto a valid/last stream feeding the sample buffer or readout.
- Reports busy/armed/done status to the control register block.

Parameters:
DATA_W, 13, sample width (signed two's complement)
DELAY_W, 8, width of trigger-to-capture delay field
LEN_W, 10, width of capture length field (max 1023 samples)

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  synchronous, active-high reset
arm  in  1  single-cycle arm request
abort  in  1  single-cycle abort request
trig  in  1  trigger level, already synchronous to clk
delay  in  DELAY_W  trigger-to-first-sample delay in clocks; latched on arm
length  in  LEN_W  samples per capture; latched on arm
din  in  DATA_W signed  converted sample stream, one sample per clk
dout  out  DATA_W signed  captured sample
dout_valid  out  1  dout carries a captured sample
dout_last  out  1  final sample of the capture (qualified by dout_valid)
armed  out  1  high in ARMED
busy  out  1  high in ARMED, DELAY, CAPTURE
done  out  1  one-cycle pulse when a capture completes
sat_count  out  LEN_W  saturated-sample count (see Optional Feature)

Behaviour:
- Reset (rst=1 at a posedge): state IDLE; dout=0, dout_valid=0, dout_last=0, armed=0, busy=0, done=0, sat_count=0; trig_q=0; latched delay/length=0. Priority order: rst > abort > normal transitions.
- Edge detect: rise = trig & ~trig_q. trig_q is registered every cycle in all states.
- IDLE:
  - arm=1 and length!=0 -> ARMED; latch delay (D) and length (L).
  - arm with length==0 is ignored (stay IDLE).
- ARMED:
  - rise at posedge E -> DELAY if D!=0, with counter=D.
  - rise at posedge E -> CAPTURE if D==0.
  - A trig already high when ARMED is entered does not fire; a fresh low-to-high transition is required.
- DELAY: counter decrements each cycle; on the edge where counter==1 -> CAPTURE.
- CAPTURE:
  - Each posedge registers dout<=din, dout_valid<=1, and increments the sample index.
  - Captured samples are din at edges E+1+D through E+D+L.
  - dout_last=1 alongside the sample at index L-1, then -> DONE.
- DONE: done=1 for exactly one cycle, dout_valid=0, then -> IDLE. arm during DONE is ignored.
- dout_valid/dout_last are 0 outside CAPTURE output cycles. dout holds its last value when not valid.
- Events ignored while busy: arm in any non-IDLE state; trig edges in DELAY/CAPTURE (no re-trigger).
- abort:
  - In any state -> IDLE at the next edge, with dout_valid=0, dout_last=0, no done pulse.
  - abort and arm in the same IDLE cycle: abort wins, stays IDLE.
- Counters: index counter LEN_W bits; it never wraps because L<=2^LEN_W-1. L=1 gives a single sample with valid and last together.

Optional Feature:
Macro ADC_SAT_COUNT_EN.
- Defined:
  - sat_count increments once per captured sample equal to +4095 or -4096 (full scale), saturating at 2^LEN_W-1.
  - Cleared on entry to ARMED; holds its value after DONE until the next arm.
- Undefined: the port is still present and tied to 0, with no counter logic.

Decomposition:
- Shared package/header: state encoding constants (IDLE, ARMED, DELAY, CAPTURE, DONE); full-scale constants SAT_POS=+4095 and SAT_NEG=-4096 derived from DATA_W.
- One natural sub-module, capture_window_counter: loadable down-counter for the delay plus an up-counter with terminal flag for the index, both instantiated by the FSM.

Test Plan:
1. arm with D=0, L=4, din ramp 100,101,...; trig rise at edge E -> dout_valid on 4 cycles with dout = din at E+1..E+4; last on the 4th sample; done one cycle later; busy low after.
2. D=3, L=2 -> samples are din at E+4, E+5; no valid during the 3 delay cycles.
3. trig held high before arm, then arm -> stays ARMED; trig low then high -> capture proceeds normally.
4. abort mid-CAPTURE at index 5 of L=10 -> valid drops next cycle; no last, no done; state IDLE. A new arm is accepted next cycle.
5. length=0 with arm -> stays IDLE, armed=0. L=1 -> single sample with valid=last=1.
6. With ADC_SAT_COUNT_EN, L=8, din = {4095,0,-4096,-4096,5,4095,1,2} -> sat_count=4 after done; re-arm clears it to 0.
